// File: rtl/sinc_mclk_pkg.sv
// sinc_mclk_pkg
//   Shared definitions for the multi-channel modulator clock generator:
//   default sizing, the strobe pair type and the phase preload clamp.
package sinc_mclk_pkg;

   localparam int NUM_CH_DEF = 4;
   localparam int DIV_W_DEF  = 16;

   // Registered edge strobes of one channel.
   typedef struct packed {
      logic rise;
      logic fall;
   } strb_t;

   // A phase preload at or beyond the half-period would never reach the
   // toggle compare, so it restarts the count from zero instead.
   function automatic logic [31:0] phase_clamp(input logic [31:0] p,
                                               input logic [31:0] d);
      return (p < d) ? p : 32'd0;
   endfunction

endpackage

// File: rtl/sinc_mclk_chan.sv
// sinc_mclk_chan
//   One modulator clock channel: half-period counter, latched divider,
//   glitch-free toggle and registered rise/fall strobes.
// Ports:
//   clk_i      system clock (rising edge)
//   rst_i      synchronous active-high reset
//   run_i      channel running (global enable AND channel enable)
//   sync_i     realign request
//   mdiv_i     requested half-period in clk_i cycles
//   phase_i    counter preload applied on sync
//   mclk_o     modulator clock
//   rise_o     high in the first cycle mclk_o reads 1
//   fall_o     high in the first cycle mclk_o reads 0
//   cfg_err_o  high while the active divider is zero
module sinc_mclk_chan
   import sinc_mclk_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             sync_i,
   input  logic [DIV_W-1:0] mdiv_i,
   input  logic [DIV_W-1:0] phase_i,
   output logic             mclk_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic             cfg_err_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             mclk_q, mclk_d;
   logic             err_q, err_d;
   strb_t            strb_q, strb_d;

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      mclk_d = mclk_q;
      err_d  = err_q;
      strb_d = '0;
      if (sync_i) begin
         // Realign drops mclk silently: no fall strobe even if it was high.
         div_d  = mdiv_i;
         mclk_d = 1'b0;
         cnt_d  = DIV_W'(phase_clamp(32'(phase_i), 32'(mdiv_i)));
      end else if (!run_i) begin
         // Frozen: count and level hold, but track config so a divider
         // written while disabled is live on the first running cycle.
         div_d = mdiv_i;
      end else if (div_q == '0) begin
         mclk_d = 1'b0;
         cnt_d  = '0;
         err_d  = 1'b1;
         div_d  = mdiv_i;
      end else begin
         err_d = 1'b0;
         if (cnt_q == div_q - DIV_W'(1)) begin
            mclk_d      = ~mclk_q;
            cnt_d       = '0;
            strb_d.rise = ~mclk_q;
            strb_d.fall = mclk_q;
            // Divider changes only land at the end of a full period.
            if (mclk_q) div_d = mdiv_i;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         div_q  <= '0;
         mclk_q <= 1'b0;
         err_q  <= 1'b0;
         strb_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         mclk_q <= mclk_d;
         err_q  <= err_d;
         strb_q <= strb_d;
      end
   end

   assign mclk_o    = mclk_q;
   assign rise_o    = strb_q.rise;
   assign fall_o    = strb_q.fall;
   assign cfg_err_o = err_q;

endmodule

// File: rtl/sinc_mclk_gen_multi.sv
// sinc_mclk_gen_multi
//   NUM_CH independent modulator clocks for the sinc filter front end.
// Ports:
//   sys_clk    system clock (rising edge)
//   reset      synchronous active-high reset
//   enable     global run enable
//   ch_en      per-channel run enable
//   mdiv       packed per-channel half-periods, channel i at [i*DIV_W +: DIV_W]
//   phase      packed per-channel sync preloads, same packing
//   sync       realign all channels
//   mclk       modulator clocks
//   mclk_rise  per-channel rise strobes
//   mclk_fall  per-channel fall strobes
//   cfg_err    per-channel zero-divider flags
module sinc_mclk_gen_multi
   import sinc_mclk_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH*DIV_W-1:0] mdiv,
   input  logic [NUM_CH*DIV_W-1:0] phase,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       mclk,
   output logic [NUM_CH-1:0]       mclk_rise,
   output logic [NUM_CH-1:0]       mclk_fall,
   output logic [NUM_CH-1:0]       cfg_err
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sinc_mclk_chan #(.DIV_W(DIV_W)) u_chan (
         .clk_i     (sys_clk),
         .rst_i     (reset),
         .run_i     (enable & ch_en[g]),
         .sync_i    (sync),
         .mdiv_i    (mdiv[g*DIV_W +: DIV_W]),
         .phase_i   (phase[g*DIV_W +: DIV_W]),
         .mclk_o    (mclk[g]),
         .rise_o    (mclk_rise[g]),
         .fall_o    (mclk_fall[g]),
         .cfg_err_o (cfg_err[g])
      );
   end

endmodule

// File: tb/tb_sinc_mclk_gen_multi.sv
module tb_sinc_mclk_gen_multi;

   localparam int NCH = 4;
   localparam int DW  = 16;

   logic                sys_clk = 1'b0;
   logic                reset, enable, sync;
   logic [NCH-1:0]      ch_en, mclk, mclk_rise, mclk_fall, cfg_err;
   logic [NCH*DW-1:0]   mdiv, phase;

   sinc_mclk_gen_multi #(.NUM_CH(NCH), .DIV_W(DW)) dut (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .enable    (enable),
      .ch_en     (ch_en),
      .mdiv      (mdiv),
      .phase     (phase),
      .sync      (sync),
      .mclk      (mclk),
      .mclk_rise (mclk_rise),
      .mclk_fall (mclk_fall),
      .cfg_err   (cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   // cyc = number of rising edges so far; outputs seen at a negedge belong
   // to the edge numbered cyc.
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      int ch;
      bit rise;
      int at;
   } ev_t;

   ev_t            q[$];
   logic [NCH-1:0] trk = '0;
   int             n_cmp = 0;
   int             n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input bit r, input int at);
      ev_t e;
      e.ch = c; e.rise = r; e.at = at;
      q.push_back(e);
   endtask

   // End of a tracking window: every expected strobe must have been seen.
   task automatic close(input int c);
      ev_t keep[$];
      int  n = 0;
      foreach (q[i]) begin
         if (q[i].ch == c) n++;
         else keep.push_back(q[i]);
      end
      chk($sformatf("ch%0d missing strobes", c), n, 0);
      q = keep;
      trk[c] = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic set_div(input int c, input int v);
      mdiv[c*DW +: DW] = DW'(v);
   endtask

   task automatic set_ph(input int c, input int v);
      phase[c*DW +: DW] = DW'(v);
   endtask

   // Monitor: any strobe on a tracked channel must match the oldest
   // expected event for that channel.
   task automatic mon_ch(input int c);
      int idx = -1;
      for (int i = 0; i < q.size(); i++)
         if (idx < 0 && q[i].ch == c) idx = i;
      if (idx < 0) begin
         chk($sformatf("ch%0d unexpected strobe r/f", c),
             32'({mclk_rise[c], mclk_fall[c]}), 0);
      end else begin
         chk($sformatf("ch%0d strobe cycle", c), cyc, q[idx].at);
         chk($sformatf("ch%0d strobe kind r/f", c),
             32'({mclk_rise[c], mclk_fall[c]}), q[idx].rise ? 32'd2 : 32'd1);
         chk($sformatf("ch%0d level at strobe", c), 32'(mclk[c]), 32'(q[idx].rise));
         q.delete(idx);
      end
   endtask

   always @(negedge sys_clk) begin
      for (int c = 0; c < NCH; c++)
         if (trk[c] && (mclk_rise[c] || mclk_fall[c])) mon_ch(c);
   end

   initial begin
      int t, u, v, w;
      reset = 1'b1; enable = 1'b0; sync = 1'b0; ch_en = '1;
      mdiv = '0; phase = '0;
      set_div(0, 4); set_div(1, 1); set_div(2, 0); set_div(3, 5);
      tick(3);
      chk("reset mclk",    32'(mclk),      0);
      chk("reset rise",    32'(mclk_rise), 0);
      chk("reset fall",    32'(mclk_fall), 0);
      chk("reset cfg_err", 32'(cfg_err),   0);

      // One idle cycle loads div_act, then run.
      reset = 1'b0;
      tick(1);
      t = cyc;
      push(0, 1, t+4);  push(0, 0, t+8);  push(0, 1, t+12); push(0, 0, t+16);
      push(0, 1, t+18); push(0, 0, t+20); push(0, 1, t+22); push(0, 0, t+24);
      push(1, 1, t+1);  push(1, 0, t+2);  push(1, 1, t+3);  push(1, 0, t+4);
      push(3, 1, t+5);  push(3, 0, t+10); push(3, 1, t+15); push(3, 0, t+20);
      trk = '1;
      enable = 1'b1;
      tick(1);
      chk("cfg_err zero div", 32'(cfg_err), 32'(4'b0100));
      tick(4);
      close(1);
      tick(8);                  // t+13, ch0 high
      set_div(0, 2);
      tick(12);                 // t+25
      close(0); close(3);
      chk("ch2 err held",  32'(cfg_err[2]), 1);
      chk("ch2 mclk low",  32'(mclk[2]),    0);

      // Recover ch2 with a nonzero divider.
      u = cyc;
      set_div(2, 3);
      push(2, 1, u+4); push(2, 0, u+7); push(2, 1, u+10); push(2, 0, u+13);
      tick(1);
      chk("ch2 err still set", 32'(cfg_err[2]), 1);
      tick(1);
      chk("ch2 err cleared",   32'(cfg_err[2]), 0);
      tick(12);
      close(2);

      // Sync with phase = channel index, mdiv = 4 everywhere.
      for (int c = 0; c < NCH; c++) begin set_div(c, 4); set_ph(c, c); end
      sync = 1'b1;
      v = cyc;
      tick(1);
      sync = 1'b0;
      trk = '1;
      for (int c = 0; c < NCH; c++) begin
         push(c, 1, v+5-c); push(c, 0, v+9-c);
      end
      chk("sync mclk low", 32'(mclk), 0);
      tick(9);
      for (int c = 0; c < NCH; c++) close(c);

      // Clamp: phase 9 and phase == mdiv both restart from zero.
      set_ph(0, 9); set_ph(1, 4); set_ph(2, 3); set_ph(3, 0);
      sync = 1'b1;
      w = cyc;
      tick(1);
      sync = 1'b0;
      trk = '1;
      push(0, 1, w+5);
      push(1, 1, w+5);
      push(2, 1, w+2); push(2, 0, w+6);
      push(3, 1, w+5); push(3, 0, w+9); push(3, 1, w+18); push(3, 0, w+22);
      tick(6);
      close(0); close(1); close(2);

      // Freeze ch3 for 5 cycles during its low phase.
      tick(3);                  // w+10
      ch_en[3] = 1'b0;
      tick(2);
      chk("ch3 frozen low", 32'(mclk[3]), 0);
      tick(3);                  // w+15
      ch_en[3] = 1'b1;
      tick(8);                  // w+23
      close(3);

      // Reset while ch0 is high: no fall strobe.
      chk("ch0 high before reset", 32'(mclk[0]), 1);
      trk[0] = 1'b1;
      reset = 1'b1;
      tick(1);
      chk("mid reset mclk",    32'(mclk),    0);
      chk("mid reset cfg_err", 32'(cfg_err), 0);
      tick(1);
      close(0);
      reset = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
